// File: rtl/simple_bus_pkg.sv
// Shared widths and FSM state type for the simple bus scheduler.
package simple_bus_pkg;

  localparam int CMD_W  = 4;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;

  // IDLE: arbitrate, ISSUE: one-cycle bus strobe, WAIT: wait for completion or timeout
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search begins at index ptr and wraps around.
// grant is one-hot for the first requester found, or all-zero when req is empty.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk the requesters in rotated order; the first one asking wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    any_req   = |req;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/simple_bus_scheduler.sv
// Round-robin scheduler that funnels NUM_REQ requesters onto one bus, one
// transaction at a time. state_dbg mirrors the FSM state for observation.
//
// Handshake: req_ready is a combinational one-hot grant, raised only in IDLE
// and only for the round-robin winner. A request transfers on the rising edge
// where req_valid[i] and req_ready[i] are both high. After that edge the
// owner's req_valid is not looked at again. The transaction then finishes
// with a single-cycle pulse on either req_done[i] or req_err[i].
module simple_bus_scheduler
  import simple_bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*CMD_W-1:0]  req_cmd,
  input  logic [NUM_REQ*ADDR_W-1:0] req_saddr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic                      bus_en,
  output logic [CMD_W-1:0]          bus_cmd,
  output logic [ADDR_W-1:0]         bus_saddr,
  input  logic                      bus_done,
  output logic                      busy,
  output state_t                    state_dbg
);

  localparam int               IDX_W        = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state;
  // last_grant also identifies the owner while a transaction is outstanding,
  // because it changes only at the acceptance edge.
  logic [IDX_W-1:0]    last_grant;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    win_idx;
  logic [NUM_REQ-1:0]  win_grant;
  logic                any_req;
  logic                accept;
  logic [CMD_W-1:0]    win_cmd;
  logic [ADDR_W-1:0]   win_saddr;
  logic [CNT_W-1:0]    wait_cnt;

  // Search starts one past the previous winner
  always_comb begin
    ptr = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .any_req   (any_req)
  );

  // Select the winner's command and address with an AND-OR mux on the grant
  always_comb begin
    win_cmd   = '0;
    win_saddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) begin
        win_cmd   = req_cmd[i*CMD_W +: CMD_W];
        win_saddr = req_saddr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Handshake and status outputs; reset suppresses grant and strobe immediately
  always_comb begin
    accept    = (state == IDLE) && any_req && !rst;
    req_ready = accept ? win_grant : '0;
    bus_en    = (state == ISSUE) && !rst;
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // FSM, latched transaction, wait counter and registered completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= LAST_IDX;
      bus_cmd    <= '0;
      bus_saddr  <= '0;
      wait_cnt   <= '0;
      req_done   <= '0;
      req_err    <= '0;
    end else begin
      req_done <= '0;
      req_err  <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= ISSUE;
            last_grant <= win_idx;
            bus_cmd    <= win_cmd;
            bus_saddr  <= win_saddr;
          end
        end
        ISSUE: begin
          // bus_done is deliberately ignored here
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (bus_done) begin
            // completion takes priority over a simultaneous timeout
            state                <= IDLE;
            req_done[last_grant] <= 1'b1;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state               <= IDLE;
            req_err[last_grant] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_bus_scheduler.sv
// Testbench for simple_bus_scheduler. It uses NUM_REQ=4 and TIMEOUT=8.
module tb_simple_bus_scheduler;
  import simple_bus_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*4-1:0]  req_cmd;
  logic [N*16-1:0] req_saddr;
  logic [N-1:0]    req_ready, req_done, req_err;
  logic            bus_en;
  logic [3:0]      bus_cmd;
  logic [15:0]     bus_saddr;
  logic            bus_done;
  logic            busy;
  state_t          state_dbg;

  int n_vec  = 0;
  int n_miss = 0;
  int m_last;               // reference model: most recent winner
  logic [N-1:0] exp_q[$];   // expected grant order

  // clock / reset
  always #5 clk = ~clk;

  simple_bus_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_saddr(req_saddr), .req_ready(req_ready), .req_done(req_done),
    .req_err(req_err), .bus_en(bus_en), .bus_cmd(bus_cmd),
    .bus_saddr(bus_saddr), .bus_done(bus_done), .busy(busy),
    .state_dbg(state_dbg)
  );

  // reference: first valid requester starting one past the previous winner
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = '0; bus_done = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    m_last = N - 1;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      req_cmd[i*4 +: 4]    = 4'($urandom);
      req_saddr[i*16 +: 16] = 16'($urandom);
    end
  endtask

  task automatic test_reset();
    rand_payload();
    rst = 1'b1; req_valid = '1; bus_done = 1'b0;
    tick(); tick();
    #2;
    n_vec++; if (req_ready !== '0) begin n_miss++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (bus_en !== 1'b0) begin n_miss++; $display("FAIL rst_bus_en: got %b want 0", bus_en); end
    n_vec++; if (bus_cmd !== 4'h0) begin n_miss++; $display("FAIL rst_bus_cmd: got %h want 0", bus_cmd); end
    n_vec++; if (bus_saddr !== 16'h0) begin n_miss++; $display("FAIL rst_bus_saddr: got %h want 0000", bus_saddr); end
    n_vec++; if (req_done !== '0 || req_err !== '0) begin n_miss++; $display("FAIL rst_pulses: got done %b err %b want 0000", req_done, req_err); end
    n_vec++; if (state_dbg !== IDLE) begin n_miss++; $display("FAIL rst_state: got %0d want %0d", state_dbg, IDLE); end
    rst = 1'b0; m_last = N - 1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_miss++; $display("FAIL rst_first_winner: got %b want 0001", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    apply_reset(); rand_payload();
    req_valid = 4'b0100; req_cmd[11:8] = 4'h5; req_saddr[47:32] = 16'hBEEF;
    #2;
    n_vec++; if (req_ready !== 4'b0100) begin n_miss++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick(); req_valid = '0;
    #2;
    n_vec++; if (bus_en !== 1'b1) begin n_miss++; $display("FAIL single_bus_en: got %b want 1", bus_en); end
    n_vec++; if (bus_cmd !== 4'h5 || bus_saddr !== 16'hBEEF) begin n_miss++; $display("FAIL single_payload: got %h/%h want 5/beef", bus_cmd, bus_saddr); end
    tick();
    for (int k = 2; k <= 4; k++) begin
      bus_done = (k == 4);
      #2;
      n_vec++; if (bus_en !== 1'b0 || busy !== 1'b1 || req_done !== '0) begin n_miss++; $display("FAIL single_wait%0d: got en %b busy %b done %b want 0 1 0000", k, bus_en, busy, req_done); end
      tick();
    end
    bus_done = 1'b0;
    #2;
    n_vec++; if (req_done !== 4'b0100 || req_err !== '0) begin n_miss++; $display("FAIL single_done: got done %b err %b want 0100 0000", req_done, req_err); end
    n_vec++; if (busy !== 1'b0 || bus_cmd !== 4'h5 || bus_saddr !== 16'hBEEF) begin n_miss++; $display("FAIL single_idle: got busy %b %h/%h want 0 5/beef", busy, bus_cmd, bus_saddr); end
    tick(); #2;
    n_vec++; if (req_done !== '0 || bus_en !== 1'b0) begin n_miss++; $display("FAIL single_after: got done %b en %b want 0000 0", req_done, bus_en); end
    tick();
  endtask

  task automatic test_fairness();
    int w;
    logic [N-1:0] exp;
    apply_reset(); rand_payload();
    req_valid = '1; bus_done = 1'b1;
    for (int g = 0; g < 6; g++) exp_q.push_back(N'(1 << (g % N)));
    for (int g = 0; g < 6; g++) begin
      w = 0;
      #2;
      while (req_ready == '0 && w < 10) begin tick(); #2; w++; end
      exp = exp_q.pop_front();
      n_vec++; if (req_ready !== exp) begin n_miss++; $display("FAIL fair_grant%0d: got %b want %b", g, req_ready, exp); end
      n_vec++; if (w != ((g == 0) ? 0 : 2)) begin n_miss++; $display("FAIL fair_gap%0d: got %0d want %0d", g, w, (g == 0) ? 0 : 2); end
      if (g > 0) begin
        n_vec++; if (req_done !== N'(1 << ((g - 1) % N))) begin n_miss++; $display("FAIL fair_done%0d: got %b want %b", g, req_done, N'(1 << ((g - 1) % N))); end
      end
      tick();
    end
    req_valid = '0;
    tick(); tick(); #2;
    n_vec++; if (req_done !== 4'b0010) begin n_miss++; $display("FAIL fair_last_done: got %b want 0010", req_done); end
    bus_done = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int r;
    logic [N-1:0] oh;
    apply_reset(); rand_payload();
    r = $urandom_range(0, N - 1); oh = N'(1 << r);
    req_valid = oh; #2;
    n_vec++; if (req_ready !== oh) begin n_miss++; $display("FAIL to_ready: got %b want %b", req_ready, oh); end
    tick(); req_valid = '0; bus_done = 1'b0;
    for (int k = 0; k <= TO + 2; k++) begin
      #2;
      n_vec++; if (bus_en !== 1'(k == 0)) begin n_miss++; $display("FAIL to_bus_en k=%0d: got %b want %b", k, bus_en, k == 0); end
      n_vec++; if (req_done !== '0) begin n_miss++; $display("FAIL to_no_done k=%0d: got %b want 0000", k, req_done); end
      n_vec++; if (req_err !== ((k == TO + 1) ? oh : '0)) begin n_miss++; $display("FAIL to_err k=%0d: got %b want %b", k, req_err, (k == TO + 1) ? oh : '0); end
      n_vec++; if (busy !== 1'(k <= TO)) begin n_miss++; $display("FAIL to_busy k=%0d: got %b want %b", k, busy, k <= TO); end
      tick();
    end
  endtask

  task automatic test_race();
    int r;
    logic [N-1:0] oh;
    apply_reset(); rand_payload();
    r = $urandom_range(0, N - 1); oh = N'(1 << r);
    req_valid = oh; tick(); req_valid = '0;
    for (int k = 0; k <= TO + 2; k++) begin
      bus_done = (k == TO);
      #2;
      n_vec++; if (req_err !== '0) begin n_miss++; $display("FAIL race_no_err k=%0d: got %b want 0000", k, req_err); end
      n_vec++; if (req_done !== ((k == TO + 1) ? oh : '0)) begin n_miss++; $display("FAIL race_done k=%0d: got %b want %b", k, req_done, (k == TO + 1) ? oh : '0); end
      tick();
    end
    bus_done = 1'b0;
  endtask

  task automatic test_early_done();
    int r;
    logic [N-1:0] oh;
    apply_reset(); rand_payload();
    r = $urandom_range(0, N - 1); oh = N'(1 << r);
    req_valid = oh; tick(); req_valid = '0;
    for (int k = 0; k <= 5; k++) begin
      bus_done = (k == 0 || k == 3);
      #2;
      n_vec++; if (req_done !== ((k == 4) ? oh : '0)) begin n_miss++; $display("FAIL early_done k=%0d: got %b want %b", k, req_done, (k == 4) ? oh : '0); end
      n_vec++; if (busy !== 1'(k <= 3)) begin n_miss++; $display("FAIL early_busy k=%0d: got %b want %b", k, busy, k <= 3); end
      tick();
    end
    bus_done = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    apply_reset(); rand_payload();
    req_valid = 4'b0100; tick(); req_valid = '0;
    tick(); tick();
    rst = 1'b1; bus_done = 1'b1; req_valid = '1;
    #2;
    n_vec++; if (req_ready !== '0) begin n_miss++; $display("FAIL rmw_ready_in_rst: got %b want 0000", req_ready); end
    tick();
    rst = 1'b0; bus_done = 1'b0; m_last = N - 1;
    #2;
    n_vec++; if (busy !== 1'b0 || bus_en !== 1'b0 || state_dbg !== IDLE) begin n_miss++; $display("FAIL rmw_state: got busy %b en %b st %0d want 0 0 0", busy, bus_en, state_dbg); end
    n_vec++; if (bus_cmd !== 4'h0 || bus_saddr !== 16'h0) begin n_miss++; $display("FAIL rmw_bus: got %h/%h want 0/0000", bus_cmd, bus_saddr); end
    n_vec++; if (req_done !== '0 || req_err !== '0) begin n_miss++; $display("FAIL rmw_pulse: got done %b err %b want 0000 0000", req_done, req_err); end
    n_vec++; if (req_ready !== 4'b0001) begin n_miss++; $display("FAIL rmw_next_winner: got %b want 0001", req_ready); end
    tick(); req_valid = '0;
    #2;
    n_vec++; if (req_done !== '0 || req_err !== '0) begin n_miss++; $display("FAIL rmw_late_pulse: got done %b err %b want 0000 0000", req_done, req_err); end
    n_vec++; if (bus_en !== 1'b1 || bus_cmd !== req_cmd[3:0]) begin n_miss++; $display("FAIL rmw_issue0: got en %b cmd %h want 1 %h", bus_en, bus_cmd, req_cmd[3:0]); end
    tick();
  endtask

  task automatic test_random(input int n_cycles);
    int b, t_out, d, owner, pick;
    bit txn, is_err, idle;
    logic [3:0] cm;
    logic [15:0] ad;
    logic [N-1:0] exp_ready, exp_done, exp_err;
    apply_reset();
    txn = 0; b = 0; t_out = 0; d = 0; owner = 0; is_err = 0; cm = '0; ad = '0;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      idle = !txn || cyc >= t_out;
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) req_valid = '0;
      rand_payload();
      if (txn && cyc > b && cyc < t_out) bus_done = !is_err && (cyc == b + 1 + d);
      else bus_done = 1'($urandom_range(0, 1));
      #2;
      pick = idle ? rr_pick(req_valid, m_last) : -1;
      exp_ready = (pick >= 0) ? N'(1 << pick) : '0;
      exp_done  = (txn && cyc == t_out && !is_err) ? N'(1 << owner) : '0;
      exp_err   = (txn && cyc == t_out && is_err) ? N'(1 << owner) : '0;
      n_vec++; if (req_ready !== exp_ready) begin n_miss++; $display("FAIL rnd_ready c=%0d: got %b want %b", cyc, req_ready, exp_ready); end
      n_vec++; if (req_done !== exp_done) begin n_miss++; $display("FAIL rnd_done c=%0d: got %b want %b", cyc, req_done, exp_done); end
      n_vec++; if (req_err !== exp_err) begin n_miss++; $display("FAIL rnd_err c=%0d: got %b want %b", cyc, req_err, exp_err); end
      n_vec++; if (bus_en !== 1'(txn && cyc == b)) begin n_miss++; $display("FAIL rnd_bus_en c=%0d: got %b want %b", cyc, bus_en, txn && cyc == b); end
      n_vec++; if (busy !== 1'(!idle)) begin n_miss++; $display("FAIL rnd_busy c=%0d: got %b want %b", cyc, busy, !idle); end
      if (txn) begin
        n_vec++; if (bus_cmd !== cm || bus_saddr !== ad) begin n_miss++; $display("FAIL rnd_payload c=%0d: got %h/%h want %h/%h", cyc, bus_cmd, bus_saddr, cm, ad); end
      end
      if (pick >= 0) begin
        txn = 1; owner = pick; m_last = pick;
        cm = req_cmd[pick*4 +: 4]; ad = req_saddr[pick*16 +: 16];
        b = cyc + 1;
        d = $urandom_range(0, TO + 1);
        is_err = (d >= TO);
        t_out = is_err ? b + TO + 1 : b + d + 2;
      end
      tick();
    end
    req_valid = '0; bus_done = 1'b0;
    repeat (TO + 4) tick();
  endtask

  // watchdog: a hung run still reports
  initial begin
    #200000;
    n_miss++;
    $display("FAIL watchdog: got no completion by 200000ns want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_race();
    test_early_done();
    test_reset_mid_wait();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
